// File: rtl/mem_pkg.sv
// Shared definitions for the multi-cycle memory access controller:
// access size encodings, controller states and default memory size.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int unsigned MEM_BYTES_DEF = 65536;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    FAULT
  } state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lane_unit.sv
// Byte/half lane handling between a 32-bit memory word and the datapath.
// Ports: word_i (memory word), lane_i (addr[1:0]), size_i, uns_i,
//   wdata_i (store data, low bits used);
//   load_o (extracted + extended load value),
//   merge_o (word_i with the addressed lane replaced by wdata_i).
module lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        sb;
  logic        sh;

  always_comb begin
    b       = word_i[{lane_i, 3'b000} +: 8];
    h       = word_i[{lane_i[1], 4'b0000} +: 16];
    sb      = ~uns_i & b[7];
    sh      = ~uns_i & h[15];
    load_o  = word_i;
    merge_o = word_i;
    case (size_i)
      SZ_B: begin
        load_o = {{24{sb}}, b};
        merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_H: begin
        load_o = {{16{sh}}, h};
        merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        load_o  = word_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle memory access controller: loads with extension, sub-word
// stores via read-modify-write, alignment/range faults, IR/MDR latching.
// Ports: clk, rst (async high); req/we/size/uns/fetch/addr/wdata request;
//   mem_dout read data from memory; busy/done/err status; mdr, ir results;
//   mem_adr/mem_din/mem_rd/mem_wr memory side, decoded from registered state.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic              fetch,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       mem_dout,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       mdr,
  output logic [31:0]       ir,
  output logic [31:0]       mem_adr,
  output logic [31:0]       mem_din,
  output logic              mem_rd,
  output logic              mem_wr
);

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic        fetch_q, fetch_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] madr_q, madr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [ADDR_W:0] last;
  logic            fault;
  logic [31:0]     lu_word;
  logic [31:0]     lu_load;
  logic [31:0]     lu_merge;

  // Range check in ADDR_W+1 bits so addresses near the top cannot wrap.
  always_comb begin
    last  = {1'b0, addr}
          + (ADDR_W+1)'(size_bytes(size))
          - (ADDR_W+1)'(1);
    fault = (size == 2'b11)
          | ((size == SZ_H) & addr[0])
          | ((size == SZ_W) & (addr[1:0] != 2'b00))
          | (fetch & (size != SZ_W))
          | (last >= (ADDR_W+1)'(MEM_BYTES));
  end

  // Loads extract from the live memory word; stores merge into the
  // word captured during RD.
  assign lu_word = (state_q == WR) ? merge_q : mem_dout;

  lane_unit u_lane (
    .word_i  (lu_word),
    .lane_i  (lane_q),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .wdata_i (wdata_q),
    .load_o  (lu_load),
    .merge_o (lu_merge)
  );

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    lane_d  = lane_q;
    we_d    = we_q;
    uns_d   = uns_q;
    fetch_d = fetch_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    mdr_d   = mdr_q;
    ir_d    = ir_q;
    madr_d  = madr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          size_d  = size;
          lane_d  = addr[1:0];
          we_d    = we;
          uns_d   = uns;
          fetch_d = fetch;
          wdata_d = wdata;
          if (fault) begin
            state_d = FAULT;
          end else begin
            madr_d  = 32'({addr[ADDR_W-1:2], 2'b00});
            state_d = (we && size == SZ_W) ? WR : RD;
          end
        end
      end
      RD: begin
        if (we_q) begin
          merge_d = mem_dout;
          state_d = WR;
        end else begin
          if (fetch_q) ir_d  = mem_dout;
          else         mdr_d = lu_load;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      WR: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      size_q  <= SZ_B;
      lane_q  <= 2'b00;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      fetch_q <= 1'b0;
      wdata_q <= '0;
      merge_q <= '0;
      mdr_q   <= '0;
      ir_q    <= '0;
      madr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      fetch_q <= fetch_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      mdr_q   <= mdr_d;
      ir_q    <= ir_d;
      madr_q  <= madr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    mem_din = '0;
    if (state_q == WR)
      mem_din = (size_q == SZ_W) ? wdata_q : lu_merge;
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign mdr     = mdr_q;
  assign ir      = ir_q;
  assign mem_adr = madr_q;
  assign mem_rd  = (state_q == RD);
  assign mem_wr  = (state_q == WR);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a byte-array memory and a
// behavioural reference model of memory contents, MDR and IR.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic        fetch = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] mem_dout;
  logic        busy, done, err, mem_rd, mem_wr;
  logic [31:0] mdr, ir, mem_adr, mem_din;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size),
    .uns(uns), .fetch(fetch), .addr(addr), .wdata(wdata),
    .mem_dout(mem_dout), .busy(busy), .done(done), .err(err),
    .mdr(mdr), .ir(ir), .mem_adr(mem_adr), .mem_din(mem_din),
    .mem_rd(mem_rd), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  logic [7:0] dmem [0:65535];
  logic [7:0] rm   [0:65535];

  assign mem_dout = {dmem[{mem_adr[15:2], 2'd3}], dmem[{mem_adr[15:2], 2'd2}],
                     dmem[{mem_adr[15:2], 2'd1}], dmem[{mem_adr[15:2], 2'd0}]};

  always @(posedge clk) begin
    if (mem_wr) begin
      dmem[{mem_adr[15:2], 2'd0}] = mem_din[7:0];
      dmem[{mem_adr[15:2], 2'd1}] = mem_din[15:8];
      dmem[{mem_adr[15:2], 2'd2}] = mem_din[23:16];
      dmem[{mem_adr[15:2], 2'd3}] = mem_din[31:24];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic        err;
    logic [31:0] mdr;
    logic [31:0] ir;
    logic [31:0] adr;
    logic [31:0] din;
    int          cyc;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t q[$];
  int nvec = 0;
  int nbad = 0;
  logic [31:0] exp_mdr = '0;
  logic [31:0] exp_ir  = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nbad++;
      $display("FAIL %s: got %h, expected %h", nm, act, want);
    end
  endtask

  int nrd_c = 0;
  int nwr_c = 0;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      nrd_c = 0;
      nwr_c = 0;
      q.delete();
    end else begin
      exp_t e;
      if (mem_rd) nrd_c++;
      if (mem_wr) nwr_c++;
      if (!mem_wr) chk("din_idle_zero", mem_din, 32'h0);
      if (!done) chk("err_without_done", {31'b0, err}, 32'h0);
      if ((mem_rd || mem_wr) && q.size() > 0)
        chk("mem_adr", mem_adr, q[0].adr);
      if (mem_wr && q.size() > 0)
        chk("mem_din", mem_din, q[0].din);
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'h1, 32'h0);
        end else begin
          e = q.pop_front();
          chk("err", {31'b0, err}, {31'b0, e.err});
          chk("mdr", mdr, e.mdr);
          chk("ir", ir, e.ir);
          chk("latency", cyc, e.cyc);
          chk("rd_cycles", nrd_c, e.nrd);
          chk("wr_cycles", nwr_c, e.nwr);
        end
        nrd_c = 0;
        nwr_c = 0;
      end
    end
  end

  // Called at a negedge with the controller idle; returns at the negedge
  // where done is seen, so the next call issues back-to-back.
  task automatic issue(input bit w, input logic [1:0] sz, input bit u,
                       input bit f, input logic [31:0] a,
                       input logic [31:0] wd, input bit noise);
    exp_t e;
    int n, lat, k;
    bit flt;
    logic [63:0] t;
    logic [31:0] al;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    flt = (sz == 2'd3) || ((a % n) != 0) || (f && sz != 2'd2)
       || (longint'(a) + n - 1 >= 65536);
    al = a & 32'hFFFF_FFFC;
    e.err = flt; e.adr = al; e.din = '0; e.nrd = 0; e.nwr = 0;
    lat = 2;
    if (!flt) begin
      if (w) begin
        for (int i = 0; i < n; i++) rm[a + i] = wd[8*i +: 8];
        e.din = {rm[al + 3], rm[al + 2], rm[al + 1], rm[al]};
        e.nwr = 1;
        e.nrd = (n == 4) ? 0 : 1;
        lat = (n == 4) ? 2 : 3;
      end else begin
        t = '0;
        for (int i = 0; i < n; i++) t = t | (64'(rm[a + i]) << (8 * i));
        if (!u && t[8*n - 1]) t = t | (~64'h0 << (8 * n));
        if (f) exp_ir = t[31:0];
        else exp_mdr = t[31:0];
        e.nrd = 1;
      end
    end
    e.mdr = exp_mdr; e.ir = exp_ir; e.cyc = cyc + lat;
    q.push_back(e);
    req = 1'b1; we = w; size = sz; uns = u; fetch = f; addr = a; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_req", {31'b0, busy}, 32'h1);
    if (noise) begin
      req = 1'b1; we = $urandom_range(0, 1); size = $urandom_range(0, 2);
      fetch = 1'b0; addr = $urandom_range(0, 255); wdata = $urandom;
    end else begin
      req = 1'b0;
    end
    @(negedge clk);
    req = 1'b0;
    k = 0;
    while (!done && k < 8) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dmem[i] = 8'($urandom);
      rm[i]   = dmem[i];
    end
    dmem[1000] = 8'hBB; dmem[1001] = 8'hAA;
    dmem[1002] = 8'h99; dmem[1003] = 8'h88;
    for (int i = 1000; i < 1004; i++) rm[i] = dmem[i];

    #12;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_mdr", mdr, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_mem_adr", mem_adr, 32'h0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 2'd0, 1'b0, 1'b0, 32'd1001, 32'h0, 1'b0);
    chk("lb_1001", mdr, 32'hFFFF_FFAA);
    issue(1'b0, 2'd1, 1'b1, 1'b0, 32'd1002, 32'h0, 1'b0);
    chk("lhu_1002", mdr, 32'h0000_8899);
    issue(1'b0, 2'd1, 1'b0, 1'b0, 32'd1002, 32'h0, 1'b0);
    chk("lh_1002", mdr, 32'hFFFF_8899);
    issue(1'b1, 2'd0, 1'b0, 1'b0, 32'd1003, 32'h12, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 1'b0, 32'd1000, 32'h0, 1'b0);
    chk("lw_after_sb", mdr, 32'h1299_AABB);
    issue(1'b0, 2'd2, 1'b0, 1'b1, 32'd0, 32'h0, 1'b1);
    chk("fetch_ir", ir, {dmem[3], dmem[2], dmem[1], dmem[0]});
    chk("fetch_mdr_kept", mdr, 32'h1299_AABB);
    issue(1'b0, 2'd2, 1'b0, 1'b0, 32'd1002, 32'h0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 1'b0, 32'd65534, 32'h0, 1'b0);
    issue(1'b0, 2'd3, 1'b0, 1'b0, 32'd1000, 32'h0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 1'b0, 32'd65536, 32'h0, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 1'b1, 32'd1000, 32'h0, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 1'b0, 32'd65535, 32'h0, 1'b0);
    issue(1'b1, 2'd1, 1'b0, 1'b0, 32'd65534, 32'hBEEF, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 1'b0, 32'd1000, 32'hCAFE_F00D, 1'b1);

    // Reset during the write phase of a byte store.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd0; uns = 1'b0; fetch = 1'b0;
    addr = 32'd1001; wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("wr_phase_mem_wr", {31'b0, mem_wr}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_mem_wr", {31'b0, mem_wr}, 32'h0);
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_din", mem_din, 32'h0);
    chk("rst_mid_adr", mem_adr, 32'h0);
    chk("rst_mid_mdr", mdr, 32'h0);
    chk("rst_mid_ir", ir, 32'h0);
    exp_mdr = '0;
    exp_ir  = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b0, 2'd2, 1'b0, 1'b0, 32'd1000, 32'h0, 1'b0);
    chk("word_unmodified", mdr, 32'hCAFE_F00D);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      bit          f;
      int          r;
      r  = $urandom_range(0, 15);
      a  = $urandom_range(0, 255);
      if (r == 0) a = $urandom_range(65528, 65540);
      if (r == 1) a = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      f  = ($urandom_range(0, 7) == 0);
      issue($urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1, f,
            a, $urandom, $urandom_range(0, 3) == 0);
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    for (int i = 0; i < 260; i++) chk("mem_image", 32'(dmem[i]), 32'(rm[i]));
    for (int i = 65528; i < 65536; i++)
      chk("mem_image_top", 32'(dmem[i]), 32'(rm[i]));
    for (int i = 1000; i < 1004; i++)
      chk("mem_image_1000", 32'(dmem[i]), 32'(rm[i]));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
